skew_stream_arbiter: RTL and testbench
======================================

# skew_stream_arbiter

Round-robin arbiter and sequencer that shares one `skew_symmetric` unit between `NUM_REQ` requesters in the ESEKF datapath. Each requester offers a 3-element IEEE-754 single-precision vector over valid/ready. The block grants one requester, captures its vector, and streams the resulting 3x3 skew matrix row-major, one element per beat, to the downstream matrix engine. Each beat carries an element index, a source tag, and a last flag.

## Interface
Parameters:
- `WIDTH`, 32: element width; bit `WIDTH-1` is the float sign.
- `NUM_REQ`, 2: number of requesters, at least 2.
- `TAG_W`, `$clog2(NUM_REQ)`: width of the source tag.

Ports:
- `clk`  in  1: the only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  [NUM_REQ]: requester i offers a vector.
- `req_ready`  out  [NUM_REQ]: grant and accept for requester i; one-hot or zero.
- `req_vec`  in  [NUM_REQ][3][WIDTH]: vector per requester, elements x, y, z at indices 0, 1, 2.
- `out_valid`  out  1: output element valid.
- `out_ready`  in  1: downstream accepts.
- `out_data`  out  WIDTH: matrix element.
- `out_idx`  out  4: row-major element index, 0..8.
- `out_tag`  out  TAG_W: index of the granted requester.
- `out_last`  out  1: final element of the matrix.
- `busy`  out  1: high while in STREAM.

## Operation
- State machine with two states, IDLE and STREAM. Reset state is IDLE.
- IDLE:
  - The grant `g` is the first `i` with `req_valid[i]` set, searching from `rr_ptr` upward with modulo wrap.
  - `req_ready[g]=1` combinationally. All other `req_ready` bits are 0.
  - If no request is valid, every `req_ready` bit is 0.
  - On a handshake: capture `req_vec[g]` into `vec_q` and `g` into `tag_q`; set `rr_ptr <= (g+1) mod NUM_REQ`; set `idx` to the first index; go to STREAM.
- STREAM:
  - `out_valid=1`.
  - `out_data = M[idx]`, where M is the `skew_symmetric` output driven from `vec_q`.
  - `out_idx=idx`, `out_tag=tag_q`. All `req_ready` bits are 0.
- Matrix content, with `v=vec_q`:
  - M = {0, v2, -v1, -v2, 0, v0, v1, -v0, 0}.
  - Negation is a sign-bit flip only. A zero input therefore yields `-0` (sign set), which is passed through unchanged.
  - Diagonal elements are all-zero bits, i.e. +0.0.
- Advance:
  - `idx` advances only on `out_valid && out_ready`.
  - `out_last=1` when `idx` is the final index.
  - A handshake on the last element returns the block to IDLE.
- Backpressure: while `out_ready=0`, `out_data`, `out_idx`, `out_tag` and `out_last` hold stable. `vec_q` is never modified in STREAM.
- Fairness: a requester holding `req_valid` is granted within `NUM_REQ` grants.
- Reset mid-stream: the partial matrix is discarded. No `out_last` is emitted. The requester's vector is considered consumed.

## Timing
- Reset values: state IDLE, `rr_ptr=0`, `idx=0`, `vec_q=0`, `tag_q=0`.
- Output reset values: `out_valid=0`, `out_last=0`, `busy=0`, all `req_ready` bits 0.
- Latency: request handshake in cycle T gives the first `out_valid` in cycle T+1.
- Throughput with `out_ready` held high:
  - 9 beats per matrix plus 1 IDLE accept cycle.
  - One matrix every 10 cycles; every 7 cycles when `SKEW_SKIP_DIAG_EN` is defined.
- Request timing: `req_valid` may drop before it is granted. The arbiter samples it only in IDLE, and no vector is captured without the handshake.
- All outputs except `req_ready` are driven from registers or from `vec_q` through the combinational skew mux.

## Configuration
- `SKEW_SKIP_DIAG_EN` defined:
  - Diagonal beats are skipped. The `idx` sequence is 1, 2, 3, 5, 6, 7, giving 6 beats.
  - The first index is 1 and `out_last` is set at `idx=7`.
- `SKEW_SKIP_DIAG_EN` undefined:
  - The `idx` sequence is 0..8, giving 9 beats.
  - The first index is 0 and `out_last` is set at `idx=8`.

## Structure
- Package `skew_stream_pkg` contains:
  - `state_t` enum {IDLE, STREAM}.
  - `NUM_ELEM=9`.
  - `IDX_W=4`.
  - Diagonal index constants 0, 4, 8.
  - `FIRST_IDX` and `LAST_IDX`, both selected by the macro.
  - `next_idx()` function, which skips the diagonal when the macro is defined.
- One sub-module: an instance of the existing `skew_symmetric` driven by `vec_q`. Arbitration, the FSM and the index counter stay in this module.

## Test plan
- Single matrix: requester 0 presents v = {0x3F800000, 0x40000000, 0x40400000}, `out_ready=1`.
  - Beats are 0, 0x40400000, 0xC0000000, 0xC0400000, 0, 0x3F800000, 0x40000000, 0xBF800000, 0.
  - `out_tag=0` and `out_last` is set on beat 8.
- Round-robin: both requesters are held valid for 4 matrices. Tags must be 0, 1, 0, 1, and `req_ready` is never high in STREAM.
- Backpressure: toggle `out_ready` as 1, 0, 0, 1, … during a stream. `out_data` and `out_idx` stay frozen while `out_ready` is low, and there are no duplicate or missing indices.
- Zero input: v = {0, 0x80000000, 0}.
  - Element 2 = 0x00000000.
  - Elements 3 and 7 = 0x80000000.
  - Element 6 = 0x80000000.
- Reset mid-stream: assert `rst` after beat 4. On the next edge `out_valid=0`, `busy=0`, and `rr_ptr=0`. A new request restarts at the first index.
- `SKEW_SKIP_DIAG_EN` build: with the vector from the first scenario, exactly 6 beats arrive with idx 1, 2, 3, 5, 6, 7, and `out_last` is set at idx 7.

Source files
------------

// File: rtl/skew_stream_pkg.sv
// skew_stream_pkg: shared FSM states, index constants and diagonal-skip sequencing (SKEW_SKIP_DIAG_EN) for skew_stream_arbiter
package skew_stream_pkg;
  typedef enum logic {IDLE, STREAM} state_t;
  localparam int NUM_ELEM = 9;
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] DIAG0 = 4'd0;
  localparam logic [IDX_W-1:0] DIAG1 = 4'd4;
  localparam logic [IDX_W-1:0] DIAG2 = 4'd8;
`ifdef SKEW_SKIP_DIAG_EN
  localparam bit SKIP_DIAG = 1'b1;
  localparam logic [IDX_W-1:0] FIRST_IDX = 4'd1;
  localparam logic [IDX_W-1:0] LAST_IDX = 4'd7;
`else
  localparam bit SKIP_DIAG = 1'b0;
  localparam logic [IDX_W-1:0] FIRST_IDX = DIAG0;
  localparam logic [IDX_W-1:0] LAST_IDX = DIAG2;
`endif
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] n;
    n = i + 1'b1;
    return (SKIP_DIAG && n == DIAG1) ? n + 1'b1 : n;
  endfunction
endpackage

// File: rtl/skew_stream_arbiter_skew.sv
// skew_symmetric: vec[2:0] (x,y,z) -> mat[8:0] row-major skew matrix, negation by sign-bit flip, diagonal +0.0
module skew_symmetric #(
  parameter int WIDTH = 32
) (
  input  logic [2:0][WIDTH-1:0] vec,
  output logic [8:0][WIDTH-1:0] mat
);
  localparam logic [WIDTH-1:0] SIGN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZERO = '0;
  assign mat = {ZERO, vec[0] ^ SIGN, vec[1], vec[0], ZERO, vec[2] ^ SIGN, vec[1] ^ SIGN, vec[2], ZERO};
endmodule

// File: rtl/skew_stream_arbiter.sv
// skew_stream_arbiter: round-robin grant of req_valid/req_ready/req_vec, streams 3x3 skew matrix on out_valid/out_ready/out_data/out_idx/out_tag/out_last, busy in STREAM; SKEW_SKIP_DIAG_EN skips diagonal beats
module skew_stream_arbiter
  import skew_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM_REQ = 2,
  parameter int TAG_W = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][2:0][WIDTH-1:0] req_vec,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  out_data,
  output logic [IDX_W-1:0]                  out_idx,
  output logic [TAG_W-1:0]                  out_tag,
  output logic                              out_last,
  output logic                              busy
);
  state_t state, state_nx;
  logic [TAG_W-1:0] rr_ptr, tag_q, g, j;
  logic [IDX_W-1:0] idx;
  logic [2:0][WIDTH-1:0] vec_q;
  logic [8:0][WIDTH-1:0] mat;
  logic found, accept, beat, at_last;
  always_comb begin
    found = 1'b0;
    g = '0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = TAG_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[j]) begin
        found = 1'b1;
        g = j;
      end
    end
  end
  assign accept = state == IDLE && found;
  assign beat = state == STREAM && out_ready;
  assign at_last = idx == LAST_IDX;
  assign req_ready = accept ? {{(NUM_REQ-1){1'b0}}, 1'b1} << g : '0;
  always_comb begin
    state_nx = state;
    state_nx = accept ? STREAM : (beat && at_last) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      idx <= '0;
      vec_q <= '0;
      tag_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        vec_q <= req_vec[g];
        tag_q <= g;
        rr_ptr <= TAG_W'((int'(g) + 1) % NUM_REQ);
      end
      if (accept || beat) idx <= (accept || at_last) ? FIRST_IDX : next_idx(idx);
    end
  end
  skew_symmetric #(.WIDTH(WIDTH)) u_skew (.vec(vec_q), .mat(mat));
  assign out_valid = state == STREAM;
  assign busy = out_valid;
  assign out_data = mat[idx];
  assign out_idx = idx;
  assign out_tag = tag_q;
  assign out_last = out_valid && at_last;
endmodule

// File: tb/tb_skew_stream_arbiter.sv
// tb_skew_stream_arbiter: randomized and directed checks of skew_stream_arbiter against a queue-based beat model
module tb_skew_stream_arbiter;
  localparam int N = 2;
  localparam int W = 32;
  localparam logic [31:0] EXP1 [9] = '{32'h0, 32'h40400000, 32'hC0000000, 32'hC0400000, 32'h0,
                                       32'h3F800000, 32'h40000000, 32'hBF800000, 32'h0};
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready;
  logic [N-1:0][2:0][W-1:0] req_vec;
  logic out_valid, out_ready, out_last, busy;
  logic [W-1:0] out_data;
  logic [3:0] out_idx;
  logic [0:0] out_tag;
  skew_stream_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_vec(req_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_tag(out_tag), .out_last(out_last), .busy(busy)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int seq[$];
  int tags[$];
  bit m_busy = 0, stalled = 0;
  int m_ptr = 0, m_tag = 0, m_pos = 0, m_done = 0, cyc = 0, mode = 0, n_beats = 0;
  logic [2:0][W-1:0] m_vec;
  logic [W-1:0] obs [9];
  logic [35:0] prev;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [W-1:0] elem(input logic [2:0][W-1:0] v, input int i);
    logic [W-1:0] s;
    s = 32'h8000_0000;
    case (i)
      1: return v[2];
      2: return v[1] ^ s;
      3: return v[2] ^ s;
      5: return v[0];
      6: return v[1];
      7: return v[0] ^ s;
      default: return '0;
    endcase
  endfunction
  function automatic int pick(input int ptr, input logic [N-1:0] val);
    for (int k = 0; k < N; k++) if (val[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction
  task automatic step();
    #2;
    if (rst) begin
      m_busy = 0;
      m_ptr = 0;
      stalled = 0;
    end
    check("out_valid", out_valid, m_busy);
    check("busy", busy, m_busy);
    if (m_busy) begin
      check("req_ready_stream", req_ready, 0);
      check("out_idx", out_idx, seq[m_pos]);
      check("out_data", out_data, elem(m_vec, seq[m_pos]));
      check("out_tag", out_tag, m_tag);
      check("out_last", out_last, m_pos == seq.size() - 1);
      if (stalled) check("frozen", {out_idx, out_data}, prev);
      prev = {out_idx, out_data};
      stalled = !out_ready;
      if (out_ready) begin
        obs[out_idx] = out_data;
        n_beats++;
        m_pos++;
        if (m_pos == seq.size()) begin
          m_busy = 0;
          m_done++;
        end
      end
    end else begin
      int g = pick(m_ptr, req_valid);
      check("req_ready", req_ready, g < 0 ? 0 : (1 << g));
      check("out_last_idle", out_last, 0);
      if (g >= 0 && !rst) begin
        m_busy = 1;
        m_tag = g;
        m_vec = req_vec[g];
        m_ptr = (g + 1) % N;
        m_pos = 0;
        tags.push_back(g);
      end
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic drive();
    if (mode == 0) out_ready = 1'b1;
    else if (mode == 1) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
    else begin
      out_ready = $urandom_range(0, 3) != 0;
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) for (int e = 0; e < 3; e++) req_vec[i][e] = $urandom;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic run_matrices(input int n, input int budget);
    int start, c;
    start = m_done;
    c = 0;
    while (m_done < start + n && c < budget) begin
      drive();
      step();
      c++;
    end
    if (m_done < start + n) check("timeout", m_done, start + n);
  endtask
  task automatic rand_vecs();
    for (int i = 0; i < N; i++) for (int e = 0; e < 3; e++) req_vec[i][e] = $urandom;
  endtask
  initial begin
    for (int i = 0; i < 9; i++)
`ifdef SKEW_SKIP_DIAG_EN
      if (i % 4 != 0) seq.push_back(i);
`else
      seq.push_back(i);
`endif
    rst = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    rand_vecs();
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 9; i++) obs[i] = 32'hDEAD_BEEF;
    n_beats = 0;
    req_vec[0] = {32'h40400000, 32'h40000000, 32'h3F800000};
    req_valid = 2'b01;
    mode = 0;
    run_matrices(1, 30);
    req_valid = '0;
    foreach (seq[i]) check("single_elem", obs[seq[i]], EXP1[seq[i]]);
    check("single_tag", tags[tags.size() - 1], 0);
`ifdef SKEW_SKIP_DIAG_EN
    check("single_beats", n_beats, 6);
`else
    check("single_beats", n_beats, 9);
`endif
    step();
    do_reset();
    tags.delete();
    rand_vecs();
    req_valid = 2'b11;
    run_matrices(4, 60);
    req_valid = '0;
    for (int i = 0; i < 4; i++) check("rr_tag", i < tags.size() ? tags[i] : -1, i % 2);
    step();
    rand_vecs();
    req_valid = 2'b11;
    mode = 1;
    run_matrices(2, 100);
    req_valid = '0;
    mode = 0;
    step();
    req_vec[0] = {32'h0, 32'h80000000, 32'h0};
    req_valid = 2'b01;
    run_matrices(1, 30);
    req_valid = '0;
    check("zero_e2", obs[2], 32'h0);
    check("zero_e3", obs[3], 32'h80000000);
    check("zero_e6", obs[6], 32'h80000000);
    check("zero_e7", obs[7], 32'h80000000);
    step();
    do_reset();
    rand_vecs();
    req_valid = 2'b01;
    for (int c = 0; c < 20 && !(m_busy && m_pos == 5); c++) begin
      drive();
      step();
    end
    check("midstream_reached", m_busy && m_pos == 5, 1);
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tags.delete();
    req_valid = 2'b11;
    run_matrices(1, 30);
    req_valid = '0;
    check("rr_ptr_after_reset", tags.size() > 0 ? tags[0] : -1, 0);
    step();
    mode = 2;
    for (int c = 0; c < 400; c++) begin
      drive();
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end
endmodule
